// File: rtl/pcm_page_capture.sv
// pcm_page_capture: captures one page-read burst of 16-bit PCM words into a
// small buffer, keeps a running checksum and a sticky overflow flag, and
// shows a selected byte or the capture status on the LEDs.
//
// Optional feature macro: PCM_CAP_XSUM_EN
//   defined   : xsum accumulates stored words (mod 2^16); checksum view live.
//   undefined : no adder; xsum is tied to zero and the checksum view shows 0.
//
// Handshake: cap_valid qualifies cap_data and cap_last in the same cycle.
// There is no ready, because the sink always accepts. A word that cannot be
// stored (buffer full) is dropped and sets overflow. cap_last without
// cap_valid is ignored. cap_start has priority over cap_valid.
module pcm_page_capture #(
  parameter int DEPTH_LOG2 = 3,
  parameter int DW         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap_start,
  input  logic                  cap_valid,
  input  logic [DW-1:0]         cap_data,
  input  logic                  cap_last,
  input  logic [7:0]            sw,
  output logic [7:0]            led,
  output logic                  cap_busy,
  output logic                  done,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   word_cnt,
  output logic [DW-1:0]         xsum,
  output logic [1:0]            state_dbg
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // Buffer storage; not reset, reads are gated by word_cnt.
  logic [DW-1:0] mem [DEPTH];

  logic                  full;
  logic                  accept;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_addr;

  assign full      = (word_cnt == (DEPTH_LOG2+1)'(DEPTH));
  assign accept    = (state == FILL) && cap_valid && !cap_start;
  assign wr_en     = accept && !full;
  assign wr_addr   = word_cnt[DEPTH_LOG2-1:0];
  assign state_dbg = state;

`ifdef PCM_CAP_XSUM_EN
  logic [DW-1:0] xsum_q;
  assign xsum = xsum_q;
`else
  assign xsum = '0;
`endif

  // Capture FSM: start/restart, store-or-drop each word, finish on cap_last.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cap_busy <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      word_cnt <= '0;
`ifdef PCM_CAP_XSUM_EN
      xsum_q   <= '0;
`endif
    end else if (cap_start) begin
      state    <= FILL;
      cap_busy <= 1'b1;
      done     <= 1'b0;
      overflow <= 1'b0;
      word_cnt <= '0;
`ifdef PCM_CAP_XSUM_EN
      xsum_q   <= '0;
`endif
    end else if (accept) begin
      if (full) begin
        overflow <= 1'b1;
      end else begin
        word_cnt <= word_cnt + 1'b1;
`ifdef PCM_CAP_XSUM_EN
        xsum_q   <= xsum_q + cap_data;
`endif
      end
      if (cap_last) begin
        state    <= DONE;
        cap_busy <= 1'b0;
        done     <= 1'b1;
      end
    end
  end

  // Buffer write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= cap_data;
    end
  end

  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DW-1:0]         rd_word;
  logic                  rd_hit;
  logic [3:0]            cnt4;
  logic [7:0]            led_next;
  logic                  unused_sw;

  assign rd_idx    = sw[DEPTH_LOG2-1:0];
  assign rd_word   = mem[rd_idx];
  assign rd_hit    = ((DEPTH_LOG2+1)'(rd_idx) < word_cnt);
  assign cnt4      = 4'(word_cnt);
  assign unused_sw = ^sw[5:DEPTH_LOG2];

  // Display byte selection from current buffer/status and switches.
  always_comb begin
    led_next = 8'h00;
    if (!sw[7]) begin
      if (rd_hit) begin
        led_next = sw[6] ? rd_word[15:8] : rd_word[7:0];
      end
    end else if (!sw[6]) begin
      led_next = {done, overflow, cap_busy, 1'b0, cnt4};
    end else begin
`ifdef PCM_CAP_XSUM_EN
      led_next = sw[5] ? xsum_q[15:8] : xsum_q[7:0];
`else
      led_next = 8'h00;
`endif
    end
  end

  // LED register: one cycle behind switches and buffer changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= 8'h00;
    end else begin
      led <= led_next;
    end
  end

endmodule
